// File: rtl/pll_spi_arbiter.sv
// pll_spi_arbiter: round-robin arbiter between the PLL init sequencer (port 0)
// and the runtime register path (port 1), serialising one word per grant onto
// the PLL configuration SPI bus (MSB first, SCK idle low, MISO captured at the
// end of each SCK high phase).
module pll_spi_arbiter #(
  parameter int g_div       = 300,
  parameter int g_word_bits = 24
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   req0_i,
  input  logic [g_word_bits-1:0] data0_i,
  output logic                   ack0_o,
  input  logic                   req1_i,
  input  logic [g_word_bits-1:0] data1_i,
  output logic                   ack1_o,
  output logic [g_word_bits-1:0] rdata_o,
  output logic                   busy_o,
  output logic                   cs_n_o,
  output logic                   sck_o,
  output logic                   mosi_o,
  input  logic                   miso_i
);

  localparam int CW = (g_div > 1) ? $clog2(g_div) : 1;
  localparam int BW = $clog2(g_word_bits + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(g_div - 1);
  localparam logic [BW-1:0] BITS_LAST = BW'(g_word_bits - 1);
  localparam logic [BW-1:0] BITS_ALL  = BW'(g_word_bits);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SCK_HI, S_SCK_LO, S_HOLD, S_ACK, S_GAP
  } state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic [BW-1:0]          bits, bits_nxt;
  logic [g_word_bits-1:0] tx, tx_nxt;
  logic [g_word_bits-1:0] rx, rx_nxt;
  logic [g_word_bits-1:0] rdata_nxt;
  logic [g_word_bits-1:0] grant_word;
  logic                   last_grant, last_grant_nxt;
  logic                   grant;
  logic                   cs_n_nxt, sck_nxt, mosi_nxt;
  logic                   ack0_nxt, ack1_nxt, busy_nxt;
  logic                   phase_end;

  assign phase_end = (cnt == CNT_LAST);

  // Registers every piece of state, including all outputs, so the SPI pins are glitch-free.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bits       <= '0;
      tx         <= '0;
      rx         <= '0;
      last_grant <= 1'b1;
      cs_n_o     <= 1'b1;
      sck_o      <= 1'b0;
      mosi_o     <= 1'b0;
      ack0_o     <= 1'b0;
      ack1_o     <= 1'b0;
      busy_o     <= 1'b0;
      rdata_o    <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      bits       <= bits_nxt;
      tx         <= tx_nxt;
      rx         <= rx_nxt;
      last_grant <= last_grant_nxt;
      cs_n_o     <= cs_n_nxt;
      sck_o      <= sck_nxt;
      mosi_o     <= mosi_nxt;
      ack0_o     <= ack0_nxt;
      ack1_o     <= ack1_nxt;
      busy_o     <= busy_nxt;
      rdata_o    <= rdata_nxt;
    end
  end

  // Arbitration, phase timing and shifting: computes the next value of every register.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    bits_nxt       = bits;
    tx_nxt         = tx;
    rx_nxt         = rx;
    rdata_nxt      = rdata_o;
    last_grant_nxt = last_grant;
    cs_n_nxt       = cs_n_o;
    sck_nxt        = sck_o;
    mosi_nxt       = mosi_o;
    ack0_nxt       = 1'b0;
    ack1_nxt       = 1'b0;
    busy_nxt       = busy_o;
    grant          = (req0_i && req1_i) ? ~last_grant : req1_i;
    grant_word     = grant ? data1_i : data0_i;

    case (state)
      S_IDLE: begin
        if (req0_i || req1_i) begin
          last_grant_nxt = grant;
          tx_nxt         = grant_word;
          mosi_nxt       = grant_word[g_word_bits-1];
          busy_nxt       = 1'b1;
          cs_n_nxt       = 1'b0;
          cnt_nxt        = '0;
          bits_nxt       = '0;
          state_nxt      = S_SETUP;
        end
      end
      S_SETUP: begin
        if (phase_end) begin
          cnt_nxt   = '0;
          sck_nxt   = 1'b1;
          state_nxt = S_SCK_HI;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_SCK_HI: begin
        if (phase_end) begin
          cnt_nxt   = '0;
          sck_nxt   = 1'b0;
          rx_nxt    = {rx[g_word_bits-2:0], miso_i};
          bits_nxt  = bits + 1'b1;
          // The final bit stays on MOSI through HOLD rather than shifting in a zero.
          if (bits != BITS_LAST) begin
            mosi_nxt = tx[g_word_bits-2];
            tx_nxt   = {tx[g_word_bits-2:0], 1'b0};
          end
          state_nxt = S_SCK_LO;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_SCK_LO: begin
        if (phase_end) begin
          cnt_nxt = '0;
          if (bits == BITS_ALL) begin
            state_nxt = S_HOLD;
          end else begin
            sck_nxt   = 1'b1;
            state_nxt = S_SCK_HI;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_HOLD: begin
        if (phase_end) begin
          cnt_nxt   = '0;
          cs_n_nxt  = 1'b1;
          rdata_nxt = rx;
          ack0_nxt  = ~last_grant;
          ack1_nxt  = last_grant;
          state_nxt = S_ACK;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_ACK: begin
        cnt_nxt   = '0;
        state_nxt = S_GAP;
      end
      S_GAP: begin
        if (phase_end) begin
          cnt_nxt   = '0;
          busy_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pll_spi_arbiter.sv
// Testbench for pll_spi_arbiter: a transaction-timeline model (cycle offset
// since grant -> expected pin values) is compared against the DUT every cycle,
// plus directed scenarios with literal expectations on the captured SPI words.
`timescale 1ns/1ps
module tb_pll_spi_arbiter;

  localparam int D          = 2;
  localparam int W          = 24;
  localparam int CS_LOW     = (2*W+2)*D;
  localparam int ACK_K      = CS_LOW + 1;
  localparam int T_END      = (2*W+3)*D + 1;
  localparam int TXN_BUDGET = 4*T_END;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0  = 1'b0;
  logic         req1  = 1'b0;
  logic [W-1:0] data0 = '0;
  logic [W-1:0] data1 = '0;
  logic         miso  = 1'b0;
  logic         ack0, ack1, busy, cs_n, sck, mosi;
  logic [W-1:0] rdata;
  int           miso_mode = 0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pll_spi_arbiter #(.g_div(D), .g_word_bits(W)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req0_i(req0), .data0_i(data0), .ack0_o(ack0),
    .req1_i(req1), .data1_i(data1), .ack1_o(ack1),
    .rdata_o(rdata), .busy_o(busy),
    .cs_n_o(cs_n), .sck_o(sck), .mosi_o(mosi), .miso_i(miso)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: a transaction is just "k cycles since grant" plus the word and port.
  bit           m_valid  = 1'b0;
  bit           m_active = 1'b0;
  bit           m_port   = 1'b0;
  bit           m_last   = 1'b1;
  int           m_k      = 0;
  logic [W-1:0] m_word   = '0;
  logic [W-1:0] m_rx     = '0;
  logic [W-1:0] m_rdata  = '0;
  logic         m_mosi   = 1'b0;

  // Bus monitor: words seen on MOSI at SCK rising edges, CS low/high run lengths.
  logic         mon_sck  = 1'b0;
  logic         mon_cs_n = 1'b1;
  bit           mon_had  = 1'b0;
  logic [W-1:0] mon_cap  = '0;
  int           mon_low  = 0;
  int           mon_high = 0;
  int           last_gap = 0;
  int           ack0_cnt = 0;
  int           ack1_cnt = 0;
  logic [W-1:0] cap_q[$];
  int           low_q[$];

  // Advance the model on each edge, then compare all outputs 1 ns later.
  always @(posedge clk) begin
    logic e_cs_n, e_sck, e_ack0, e_ack1, e_busy;
    int   idx;
    if (!rst_n) begin
      m_valid  = 1'b1;
      m_active = 1'b0;
      m_k      = 0;
      m_rx     = '0;
      m_rdata  = '0;
      m_last   = 1'b1;
      m_mosi   = 1'b0;
    end else if (m_valid) begin
      if (m_active) begin
        if (m_k % (2*D) == 0 && m_k >= 2*D && m_k <= 2*W*D) m_rx = {m_rx[W-2:0], miso};
        if (m_k == CS_LOW) m_rdata = m_rx;
        m_k++;
        if (m_k > T_END) m_active = 1'b0;
      end else if (req0 || req1) begin
        m_port   = (req0 && req1) ? !m_last : req1;
        m_last   = m_port;
        m_word   = m_port ? data1 : data0;
        m_active = 1'b1;
        m_k      = 1;
      end
      if (m_active) begin
        idx = (m_k - 1) / (2*D);
        if (idx > W-1) idx = W-1;
        m_mosi = m_word[W-1-idx];
      end
    end
    e_cs_n = !(m_active && m_k <= CS_LOW);
    e_sck  = m_active && m_k >= D+1 && m_k <= (2*W+1)*D && (((m_k-D-1)/D) % 2 == 0);
    e_ack0 = m_active && m_k == ACK_K && !m_port;
    e_ack1 = m_active && m_k == ACK_K && m_port;
    e_busy = m_active;
    #1;
    if (m_valid) begin
      checkOutput("cs_n",  {31'd0, cs_n}, {31'd0, e_cs_n});
      checkOutput("sck",   {31'd0, sck},  {31'd0, e_sck});
      checkOutput("mosi",  {31'd0, mosi}, {31'd0, m_mosi});
      checkOutput("ack0",  {31'd0, ack0}, {31'd0, e_ack0});
      checkOutput("ack1",  {31'd0, ack1}, {31'd0, e_ack1});
      checkOutput("busy",  {31'd0, busy}, {31'd0, e_busy});
      checkOutput("rdata", {8'd0, rdata}, {8'd0, m_rdata});
      if (sck && !mon_sck) mon_cap = {mon_cap[W-2:0], mosi};
      if (!cs_n && mon_cs_n) begin
        mon_cap = '0;
        if (mon_had) last_gap = mon_high;
        mon_low = 0;
      end
      if (cs_n && !mon_cs_n) begin
        cap_q.push_back(mon_cap);
        low_q.push_back(mon_low);
        mon_high = 0;
        mon_had  = 1'b1;
      end
      if (!cs_n) mon_low++; else mon_high++;
      if (ack0) ack0_cnt++;
      if (ack1) ack1_cnt++;
      mon_sck  = sck;
      mon_cs_n = cs_n;
    end
  end

  task automatic tick();
    @(negedge clk);
    case (miso_mode)
      0:       miso = 1'b0;
      1:       miso = mosi;
      default: miso = 1'($urandom);
    endcase
  endtask

  task automatic applyStimulus(input logic r0, input logic [W-1:0] d0,
                               input logic r1, input logic [W-1:0] d1);
    req0  = r0;
    data0 = d0;
    req1  = r1;
    data1 = d1;
  endtask

  task automatic wait_ack(input int port, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < TXN_BUDGET; i++) begin
      tick();
      if ((port == 0 ? ack0 : ack1) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput({name, " ack timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_any_ack(input string name, output int port);
    bit ok;
    ok   = 1'b0;
    port = -1;
    for (int i = 0; i < TXN_BUDGET; i++) begin
      tick();
      if (ack0 === 1'b1 || ack1 === 1'b1) begin
        ok   = 1'b1;
        port = (ack1 === 1'b1) ? 1 : 0;
        break;
      end
    end
    if (!ok) checkOutput({name, " ack timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < TXN_BUDGET; i++) begin
      tick();
      if (busy === 1'b0 && cs_n === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput({name, " idle timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_sck_edges(input int n, input string name);
    int   cnt;
    logic prev;
    cnt  = 0;
    prev = sck;
    for (int i = 0; i < TXN_BUDGET && cnt < n; i++) begin
      tick();
      if (sck === 1'b1 && prev === 1'b0) cnt++;
      prev = sck;
    end
    if (cnt < n) checkOutput({name, " sck timeout"}, cnt, n);
  endtask

  // Safety net: the run must always end even if the DUT stalls forever.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios with randomized data and MISO.
  initial begin
    logic [W-1:0] d0, d1, wa;
    int           seq[4];
    int           n, port, a0_before;

    // Reset state
    applyStimulus(1'b0, '0, 1'b0, '0);
    rst_n = 1'b0;
    repeat (3) tick();
    checkOutput("reset cs_n",  {31'd0, cs_n}, 32'd1);
    checkOutput("reset sck",   {31'd0, sck},  32'd0);
    checkOutput("reset mosi",  {31'd0, mosi}, 32'd0);
    checkOutput("reset busy",  {31'd0, busy}, 32'd0);
    checkOutput("reset acks",  {30'd0, ack1, ack0}, 32'd0);
    checkOutput("reset rdata", {8'd0, rdata}, 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // 1: single port-0 word, MISO low
    miso_mode = 0;
    cap_q.delete();
    low_q.delete();
    a0_before = ack1_cnt;
    applyStimulus(1'b1, 24'h123456, 1'b0, '0);
    wait_ack(0, "t1");
    req0 = 1'b0;
    wait_idle("t1");
    checkOutput("t1 word", {8'd0, (cap_q.size() > 0) ? cap_q[0] : 24'hx}, 32'h123456);
    checkOutput("t1 cs_n low", (low_q.size() > 0) ? low_q[0] : -1, 100);
    checkOutput("t1 rdata", {8'd0, rdata}, 32'h000000);
    checkOutput("t1 no ack1", ack1_cnt - a0_before, 0);

    // 2: loopback on port 1
    miso_mode = 1;
    applyStimulus(1'b0, '0, 1'b1, 24'hA5C3F0);
    wait_ack(1, "t2");
    checkOutput("t2 rdata at ack", {8'd0, rdata}, 32'hA5C3F0);
    req1 = 1'b0;
    repeat (10) tick();
    checkOutput("t2 rdata held", {8'd0, rdata}, 32'hA5C3F0);
    wait_idle("t2");
    miso_mode = 2;

    // 3: both requesting out of reset, then re-assert, then continuous
    rst_n = 1'b0;
    applyStimulus(1'b1, 24'h111111, 1'b1, 24'h222222);
    repeat (2) tick();
    cap_q.delete();
    rst_n = 1'b1;
    wait_ack(0, "t3a");
    req0 = 1'b0;
    wait_ack(1, "t3b");
    req1 = 1'b0;
    wait_idle("t3");
    applyStimulus(1'b1, 24'h333333, 1'b1, 24'h444444);
    wait_ack(0, "t3c");
    req0 = 1'b0;
    wait_ack(1, "t3d");
    req1 = 1'b0;
    wait_idle("t3");
    checkOutput("t3 first word",  {8'd0, (cap_q.size() > 0) ? cap_q[0] : 24'hx}, 32'h111111);
    checkOutput("t3 second word", {8'd0, (cap_q.size() > 1) ? cap_q[1] : 24'hx}, 32'h222222);
    checkOutput("t3 third word",  {8'd0, (cap_q.size() > 2) ? cap_q[2] : 24'hx}, 32'h333333);
    checkOutput("t3 fourth word", {8'd0, (cap_q.size() > 3) ? cap_q[3] : 24'hx}, 32'h444444);
    applyStimulus(1'b1, W'($urandom), 1'b1, W'($urandom));
    n = 0;
    for (int i = 0; i < 8*T_END && n < 4; i++) begin
      tick();
      if (ack0 === 1'b1 || ack1 === 1'b1) begin
        seq[n] = (ack1 === 1'b1) ? 1 : 0;
        n++;
      end
      if (ack0 === 1'b1) data0 = W'($urandom);
      if (ack1 === 1'b1) data1 = W'($urandom);
      req0 = !(ack0 === 1'b1);
      req1 = !(ack1 === 1'b1);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    checkOutput("t3 alternation acks", n, 4);
    for (int i = 0; i < n; i++) checkOutput($sformatf("t3 alternation %0d", i), seq[i], i % 2);
    wait_idle("t3 alt");

    // 4: port 0 joins while port 1 is mid-transfer
    d0 = W'($urandom);
    d1 = W'($urandom);
    applyStimulus(1'b0, '0, 1'b1, d1);
    wait_sck_edges(1, "t4 start");
    repeat (30) tick();
    data0 = d0;
    req0  = 1'b1;
    wait_ack(1, "t4a");
    req1 = 1'b0;
    tick();
    req1 = 1'b1;
    wait_any_ack("t4b", port);
    checkOutput("t4 next grant", port, 0);
    checkOutput("t4 gap >= g_div+2", (last_gap >= D+2) ? 1 : 0, 1);
    checkOutput("t4 port0 word", {8'd0, (cap_q.size() > 0) ? cap_q[cap_q.size()-1] : 24'hx}, {8'd0, d0});
    req0 = 1'b0;
    wait_ack(1, "t4c");
    req1 = 1'b0;
    wait_idle("t4");

    // 5: reset pulse after the 10th SCK rising edge
    wa = W'($urandom);
    applyStimulus(1'b1, wa, 1'b0, '0);
    wait_sck_edges(10, "t5");
    rst_n = 1'b0;
    tick();
    checkOutput("t5 cs_n after reset",  {31'd0, cs_n}, 32'd1);
    checkOutput("t5 sck after reset",   {31'd0, sck},  32'd0);
    checkOutput("t5 ack after reset",   {30'd0, ack1, ack0}, 32'd0);
    checkOutput("t5 rdata after reset", {8'd0, rdata}, 32'd0);
    cap_q.delete();
    rst_n = 1'b1;
    wait_ack(0, "t5");
    req0 = 1'b0;
    wait_idle("t5");
    checkOutput("t5 retransmit word", {8'd0, (cap_q.size() > 0) ? cap_q[0] : 24'hx}, {8'd0, wa});

    // 6: port 0 drops its request early
    wa = W'($urandom);
    cap_q.delete();
    a0_before = ack0_cnt;
    applyStimulus(1'b1, wa, 1'b0, '0);
    wait_sck_edges(5, "t6");
    req0 = 1'b0;
    wait_ack(0, "t6");
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n++;
      if (busy === 1'b0) break;
    end
    checkOutput("t6 busy fall delay", n, D+1);
    wait_idle("t6");
    checkOutput("t6 ack0 pulses", ack0_cnt - a0_before, 1);
    checkOutput("t6 word", {8'd0, (cap_q.size() > 0) ? cap_q[0] : 24'hx}, {8'd0, wa});

    repeat (5) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pll_spi_arbiter.md
Name: pll_spi_arbiter

Overview:
Shares the single PLL configuration SPI bus between two requesters and serialises their register words onto it. Port 0 is the power-up PLL init sequencer and port 1 is the runtime register-access path (host/control logic). The block arbitrates round-robin, shifts one word MSB-first with programmable SCK timing, captures MISO, and returns a one-cycle acknowledge to the winning port. It sits between the requesters and the PLL SPI pins and is the only driver of cs_n_o, sck_o and mosi_o.

Parameters:
g_div, 300, length of each SCK phase in clk_i cycles (>=1; 1 for simulation)
g_word_bits, 24, bits per SPI transaction (8..32)

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  reset; synchronous, active-low
req0_i  in  1  port 0 (init sequencer) request; held until ack0_o
data0_i  in  g_word_bits  port 0 word, sampled only at grant
ack0_o  out  1  one-cycle pulse: port 0 transaction complete
req1_i  in  1  port 1 (runtime access) request; held until ack1_o
data1_i  in  g_word_bits  port 1 word, sampled only at grant
ack1_o  out  1  one-cycle pulse: port 1 transaction complete
rdata_o  out  g_word_bits  MISO word of last transaction; valid from ack cycle until next ack
busy_o  out  1  high from grant cycle to end of inter-transaction gap
cs_n_o  out  1  PLL SPI chip select, active-low
sck_o  out  1  PLL SPI clock, idle low
mosi_o  out  1  PLL SPI data out
miso_i  in  1  PLL SPI data in

Behaviour:
- One clock: clk_i. Reset: synchronous, active-low on rst_n_i. All state sampled on posedge clk_i.
- Reset values: cs_n_o=1, sck_o=0, mosi_o=0, ack0_o=0, ack1_o=0, busy_o=0, rdata_o=0, last_grant=1 (port 0 wins the first tie).
- States: IDLE, SETUP, SCK_HI, SCK_LO, HOLD, ACK, GAP. Phase counter runs 0..g_div-1. Each of SETUP, SCK_HI, SCK_LO, HOLD and GAP lasts exactly g_div cycles.
- IDLE with any req: grant. If only one port requests, grant it. If both request, grant the port != last_grant. In the grant cycle: latch the granted data into the TX shift register, record last_grant, set busy_o=1, cs_n_o=0 and mosi_o=word MSB (all registered, visible next cycle). Go to SETUP.
- SETUP: sck_o=0. Then SCK_HI.
- SCK_HI: sck_o=1. On the last cycle of the phase, shift miso_i into the RX register LSB.
- SCK_LO: sck_o=0. On entry, mosi_o takes the next bit. After the last bit, mosi_o holds that bit.
- Repeat SCK_HI/SCK_LO until exactly g_word_bits rising edges have occurred, then go to HOLD.
- HOLD: cs_n_o stays 0.
- ACK (1 cycle): cs_n_o=1, rdata_o=RX register, and the granted port's ack pulses high. Then GAP.
- GAP: cs_n_o=1, busy_o=1. Then IDLE, with busy_o=0. A grant is allowed in the first IDLE cycle.
- Timing: cs_n_o low for exactly (2*g_word_bits+2)*g_div cycles. cs_n_o high for at least g_div+2 cycles between transactions.
- Requests and data are ignored outside IDLE. If a requester deasserts req mid-transfer, the transfer still completes and ack still pulses.
- A requester must drop req in the cycle after its ack. If req is still high in IDLE, it is treated as a new request.
- ack0_o and ack1_o are never high together.
- Reset mid-transfer: the next cycle shows all reset values, with no ack and no partial rdata_o update. After release, a pending req starts a fresh transaction from the MSB.

Test Plan:
1. g_div=2, req0 with data0=0x123456, miso=0 -> mosi_o samples on 24 SCK rising edges read 0x123456 MSB-first; cs_n_o low exactly 100 cycles; one ack0_o pulse; ack1_o stays 0; rdata_o=0x000000.
2. miso_i looped to mosi_o, req1 with data1=0xA5C3F0 -> rdata_o=0xA5C3F0 in the ack1_o cycle and held until the next ack.
3. req0 and req1 both high from reset with data0=0x111111, data1=0x222222 -> 0x111111 shifted first, then 0x222222. Both re-asserted -> port 0 then port 1 again. Both continuously requesting -> strict alternation.
4. req1 held continuously, req0 asserted mid-transfer of port 1 -> next grant goes to port 0; cs_n_o high for >= g_div+2 cycles between the two transactions.
5. rst_n_i low for 1 cycle after the 10th SCK rising edge -> next cycle cs_n_o=1, sck_o=0, no ack. With req0 still high, the retransmission shows all 24 bits from the MSB.
6. req0 dropped after the 5th SCK edge -> all 24 bits still shifted, ack0_o pulses once, busy_o falls g_div+1 cycles after the ack.
